// File: rtl/doodle_physics_engine.sv
// Frame-stepped Doodle physics: serial platform scan, gravity, floor bounce, wrap and shots.
// Define PHYS_OVERRUN_CNT_EN to add overrun_cnt, a saturating count of ticks dropped while busy.
module doodle_physics_engine #(
    parameter int NUM_PLAT      = 16,
    parameter int NUM_SHOTS     = 4,
    parameter int GRAVITY       = 1,
    parameter int JUMP_VEL      = 12,
    parameter int MAX_FALL      = 10,
    parameter int X_SPEED       = 2,
    parameter int SHOT_SPEED    = 7,
    parameter int FIRE_COOLDOWN = 8,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int WRAP_MARGIN   = 25,
    parameter int DOODLE_HALF   = 6
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    frame_tick,
    input  logic                    run,
    input  logic [7:0]              keycode,
    input  logic [NUM_PLAT*10-1:0]  plat_x,
    input  logic [NUM_PLAT*10-1:0]  plat_y,
    input  logic [9:0]              plat_half_w,
    input  logic [9:0]              plat_half_h,
    output logic [9:0]              doodle_x,
    output logic [9:0]              doodle_y,
    output logic [9:0]              doodle_vy,
    output logic [9:0]              doodle_s,
    output logic                    landed,
    output logic [5:0]              landed_idx,
    output logic [NUM_SHOTS*10-1:0] shot_x,
    output logic [NUM_SHOTS*10-1:0] shot_y,
    output logic [NUM_SHOTS-1:0]    shot_valid,
    output logic                    busy,
    output logic                    frame_done
`ifdef PHYS_OVERRUN_CNT_EN
    ,
    output logic [7:0]              overrun_cnt
`endif
);

    localparam logic [9:0]         X_RESET     = 10'(SCREEN_W / 2);
    localparam logic [9:0]         Y_RESET     = 10'(SCREEN_H / 2);
    localparam logic [9:0]         HALF        = 10'(DOODLE_HALF);
    localparam logic [9:0]         JUMP_UP     = 10'(-JUMP_VEL);
    localparam logic [9:0]         FLOOR_Y     = 10'(SCREEN_H - 1 - DOODLE_HALF);
    localparam logic signed [12:0] FLOOR_LINE  = 13'(SCREEN_H - 1);
    localparam logic signed [10:0] GRAV_S      = 11'(GRAVITY);
    localparam logic signed [10:0] MAX_FALL_S  = 11'(MAX_FALL);
    localparam logic signed [11:0] X_STEP      = 12'(X_SPEED);
    localparam logic signed [11:0] WRAP_LO     = 12'(WRAP_MARGIN);
    localparam logic signed [11:0] WRAP_HI     = 12'(SCREEN_W - 1 - WRAP_MARGIN);
    localparam logic [9:0]         WRAP_TO_R   = 10'(SCREEN_W - 1 - WRAP_MARGIN - 1);
    localparam logic [9:0]         WRAP_TO_L   = 10'(WRAP_MARGIN + 1);
    localparam logic [9:0]         SHOT_STEP   = 10'(SHOT_SPEED);
    localparam logic [9:0]         SHOT_RETIRE = 10'(SHOT_SPEED + WRAP_MARGIN);

    typedef enum logic [1:0] {Idle, Scan, Update, Finish} physState_t;

    physState_t  state;
    logic [5:0]  scanIdx;
    logic [5:0]  hitIdx;
    logic        hitFound;
    logic [9:0]  hitTop;
    logic [7:0]  keyLatch;
    logic        runLatch;
    logic [7:0]  prevKey;
    logic [7:0]  cooldown;

    logic [9:0]  curX, curY, dx;
    logic [10:0] feet, platTop;
    logic [11:0] feetFall;
    logic        vyPos, topValid, scanHit;

    // Landing test for the platform currently addressed by scanIdx; 11-bit math keeps top<0 and feet overflow honest.
    always_comb begin
        curX     = plat_x[int'(scanIdx)*10 +: 10];
        curY     = plat_y[int'(scanIdx)*10 +: 10];
        feet     = {1'b0, doodle_y} + {1'b0, HALF};
        topValid = (curY >= plat_half_h);
        platTop  = {1'b0, curY} - {1'b0, plat_half_h};
        vyPos    = !doodle_vy[9] && (doodle_vy != 10'd0);
        feetFall = {1'b0, feet} + {2'b00, doodle_vy};
        dx       = (doodle_x >= curX) ? (doodle_x - curX) : (curX - doodle_x);
        scanHit  = vyPos && topValid && (feet <= platTop) &&
                   (feetFall >= {1'b0, platTop}) && (dx <= plat_half_w);
    end

    logic signed [12:0] feetVy;
    logic signed [10:0] vyGrav;
    logic signed [11:0] nx;
    logic [9:0]         vyNext, xNext;
    logic               floorHit, moveLeft, moveRight, fireEvt, freeFound;
    int                 freeIdx;

    // Next-state candidates for the single UPDATE cycle.
    always_comb begin
        feetVy   = $signed({2'b00, feet}) + $signed({{3{doodle_vy[9]}}, doodle_vy});
        floorHit = (feetVy >= FLOOR_LINE);
        vyGrav   = $signed({doodle_vy[9], doodle_vy}) + GRAV_S;
        vyNext   = (vyGrav > MAX_FALL_S) ? MAX_FALL_S[9:0] : vyGrav[9:0];

        moveRight = (keyLatch == 8'd7) || (keyLatch == 8'd79);
        moveLeft  = (keyLatch == 8'd4) || (keyLatch == 8'd80);
        nx = $signed({2'b00, doodle_x});
        if (moveRight)
            nx = nx + X_STEP;
        else if (moveLeft)
            nx = nx - X_STEP;
        if (nx <= WRAP_LO)
            xNext = WRAP_TO_R;
        else if (nx >= WRAP_HI)
            xNext = WRAP_TO_L;
        else
            xNext = nx[9:0];

        fireEvt   = (keyLatch == 8'd30) && (prevKey != 8'd30) && (cooldown == 8'd0);
        freeFound = 1'b0;
        freeIdx   = 0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!shot_valid[i] && !freeFound) begin
                freeFound = 1'b1;
                freeIdx   = i;
            end
        end
    end

    assign doodle_s = HALF;

    // Frame sequencer: IDLE -> SCAN (one platform per clock) -> UPDATE -> FINISH pulse -> IDLE.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= Idle;
            scanIdx    <= '0;
            hitIdx     <= '0;
            hitFound   <= 1'b0;
            hitTop     <= '0;
            keyLatch   <= '0;
            runLatch   <= 1'b0;
            prevKey    <= '0;
            cooldown   <= '0;
            doodle_x   <= X_RESET;
            doodle_y   <= Y_RESET;
            doodle_vy  <= '0;
            landed     <= 1'b0;
            landed_idx <= '0;
            shot_x     <= '0;
            shot_y     <= '0;
            shot_valid <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef PHYS_OVERRUN_CNT_EN
            overrun_cnt <= '0;
`endif
        end else begin
            landed     <= 1'b0;
            frame_done <= 1'b0;
`ifdef PHYS_OVERRUN_CNT_EN
            if (frame_tick && busy && (overrun_cnt != 8'hFF))
                overrun_cnt <= overrun_cnt + 8'd1;
`endif
            case (state)
                Idle: begin
                    if (frame_tick) begin
                        keyLatch <= keycode;
                        runLatch <= run;
                        busy     <= 1'b1;
                        scanIdx  <= '0;
                        hitFound <= 1'b0;
                        state    <= run ? Scan : Update;
                    end
                end
                Scan: begin
                    if (scanHit && !hitFound) begin
                        hitFound <= 1'b1;
                        hitIdx   <= scanIdx;
                        hitTop   <= platTop[9:0];
                    end
                    if (int'(scanIdx) == NUM_PLAT - 1)
                        state <= Update;
                    else
                        scanIdx <= scanIdx + 6'd1;
                end
                Update: begin
                    if (runLatch) begin
                        if (hitFound) begin
                            doodle_y   <= hitTop - HALF;
                            doodle_vy  <= JUMP_UP;
                            landed     <= 1'b1;
                            landed_idx <= hitIdx;
                        end else if (floorHit) begin
                            doodle_y   <= FLOOR_Y;
                            doodle_vy  <= JUMP_UP;
                            landed     <= 1'b1;
                            landed_idx <= 6'd63;
                        end else begin
                            doodle_y  <= doodle_y + doodle_vy;
                            doodle_vy <= vyNext;
                        end
                        doodle_x <= xNext;

                        // A slot spawned this frame was invalid on entry, so it stays put until next frame.
                        for (int i = 0; i < NUM_SHOTS; i++) begin
                            if (shot_valid[i]) begin
                                if (shot_y[i*10 +: 10] < SHOT_RETIRE)
                                    shot_valid[i] <= 1'b0;
                                else
                                    shot_y[i*10 +: 10] <= shot_y[i*10 +: 10] - SHOT_STEP;
                            end else if (fireEvt && freeFound && (freeIdx == i)) begin
                                shot_valid[i]      <= 1'b1;
                                shot_x[i*10 +: 10] <= doodle_x;
                                shot_y[i*10 +: 10] <= doodle_y;
                            end
                        end

                        if (fireEvt && freeFound)
                            cooldown <= 8'(FIRE_COOLDOWN);
                        else if (cooldown != 8'd0)
                            cooldown <= cooldown - 8'd1;
                        prevKey <= keyLatch;
                    end
                    state <= Finish;
                end
                Finish: begin
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= Idle;
                end
                default: state <= Idle;
            endcase
        end
    end

endmodule

// File: tb/tb_doodle_physics_engine.sv
// Directed self-checking bench for doodle_physics_engine: latency, gravity, landings, wrap, shots, freeze, dropped ticks.
module tb_doodle_physics_engine;

    localparam int NUM_PLAT  = 16;
    localparam int NUM_SHOTS = 4;

    logic                    Clk;
    logic                    Reset_n;
    logic                    frame_tick;
    logic                    run;
    logic [7:0]              keycode;
    logic [NUM_PLAT*10-1:0]  plat_x;
    logic [NUM_PLAT*10-1:0]  plat_y;
    logic [9:0]              plat_half_w;
    logic [9:0]              plat_half_h;
    logic [9:0]              doodle_x;
    logic [9:0]              doodle_y;
    logic [9:0]              doodle_vy;
    logic [9:0]              doodle_s;
    logic                    landed;
    logic [5:0]              landed_idx;
    logic [NUM_SHOTS*10-1:0] shot_x;
    logic [NUM_SHOTS*10-1:0] shot_y;
    logic [NUM_SHOTS-1:0]    shot_valid;
    logic                    busy;
    logic                    frame_done;
`ifdef PHYS_OVERRUN_CNT_EN
    logic [7:0]              overrun_cnt;
`endif

    int vectors;
    int miscompares;

    doodle_physics_engine #(
        .NUM_PLAT  (NUM_PLAT),
        .NUM_SHOTS (NUM_SHOTS)
    ) dut (
`ifdef PHYS_OVERRUN_CNT_EN
        .overrun_cnt (overrun_cnt),
`endif
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_tick  (frame_tick),
        .run         (run),
        .keycode     (keycode),
        .plat_x      (plat_x),
        .plat_y      (plat_y),
        .plat_half_w (plat_half_w),
        .plat_half_h (plat_half_h),
        .doodle_x    (doodle_x),
        .doodle_y    (doodle_y),
        .doodle_vy   (doodle_vy),
        .doodle_s    (doodle_s),
        .landed      (landed),
        .landed_idx  (landed_idx),
        .shot_x      (shot_x),
        .shot_y      (shot_y),
        .shot_valid  (shot_valid),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic doReset;
        @(negedge Clk);
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    task automatic clearPlats;
        plat_x      = '0;
        plat_y      = '0;
        plat_half_w = 10'd20;
        plat_half_h = 10'd2;
    endtask

    // One frame: pulse the tick, then count clocks until frame_done while watching for the landed pulse.
    task automatic runFrame(input logic [7:0] key, input logic r, output int lat, output logic sawLanded);
        @(negedge Clk);
        keycode    = key;
        run        = r;
        frame_tick = 1'b1;
        @(posedge Clk);
        #1 frame_tick = 1'b0;
        lat       = 0;
        sawLanded = 1'b0;
        while (!frame_done && lat < 100) begin
            @(posedge Clk);
            #1;
            lat++;
            if (landed) sawLanded = 1'b1;
        end
        if (!frame_done) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL frame_timeout: frame_done not seen after %0d clocks, required within 100", lat);
        end
    endtask

    task automatic test_reset;
        int lat;
        Reset_n    = 1'b0;
        frame_tick = 1'b0;
        run        = 1'b1;
        keycode    = 8'd0;
        clearPlats();
        repeat (3) @(negedge Clk);
        vectors++;
        if ({doodle_x, doodle_y, doodle_vy} !== {10'd320, 10'd240, 10'd0}) begin
            miscompares++;
            $display("[TB] FAIL reset_pos: got x=%0d y=%0d vy=%0d, required 320 240 0", doodle_x, doodle_y, doodle_vy);
        end
        vectors++;
        if ({busy, frame_done, landed, landed_idx, shot_valid} !== 13'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got busy=%b done=%b landed=%b idx=%0d valid=%b, required all 0",
                     busy, frame_done, landed, landed_idx, shot_valid);
        end
        vectors++;
        if (doodle_s !== 10'd6) begin
            miscompares++;
            $display("[TB] FAIL doodle_s: got %0d, required 6", doodle_s);
        end
        // Abandon a frame part-way through the scan.
        Reset_n = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b1;
        @(posedge Clk);
        #1 frame_tick = 1'b0;
        repeat (5) @(posedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        vectors++;
        if ({busy, doodle_y, doodle_vy} !== {1'b0, 10'd240, 10'd0}) begin
            miscompares++;
            $display("[TB] FAIL midscan_reset: got busy=%b y=%0d vy=%0d, required 0 240 0", busy, doodle_y, doodle_vy);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        lat = 0;
    endtask

    task automatic test_gravity_floor;
        int   lat;
        logic sl;
        doReset();
        clearPlats();
        runFrame(8'd0, 1'b1, lat, sl);
        vectors++;
        if (lat !== 18) begin
            miscompares++;
            $display("[TB] FAIL latency_run: got %0d clocks, required 18", lat);
        end
        vectors++;
        if ({doodle_y, doodle_vy, sl} !== {10'd240, 10'd1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL gravity_f1: got y=%0d vy=%0d landed=%b, required 240 1 0", doodle_y, doodle_vy, sl);
        end
        for (int i = 2; i <= 11; i++) runFrame(8'd0, 1'b1, lat, sl);
        vectors++;
        if ({doodle_y, doodle_vy} !== {10'd295, 10'd10}) begin
            miscompares++;
            $display("[TB] FAIL terminal_vel: got y=%0d vy=%0d, required 295 10", doodle_y, doodle_vy);
        end
        for (int i = 12; i <= 28; i++) runFrame(8'd0, 1'b1, lat, sl);
        vectors++;
        if ({doodle_y, doodle_vy, sl} !== {10'd465, 10'd10, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL pre_floor: got y=%0d vy=%0d landed=%b, required 465 10 0", doodle_y, doodle_vy, sl);
        end
        runFrame(8'd0, 1'b1, lat, sl);
        vectors++;
        if ({doodle_y, doodle_vy, landed_idx, sl} !== {10'd473, 10'h3F4, 6'd63, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL floor_bounce: got y=%0d vy=%h idx=%0d landed=%b, required 473 3f4 63 1",
                     doodle_y, doodle_vy, landed_idx, sl);
        end
    endtask

    task automatic test_rising_gate;
        int   lat;
        logic sl;
        doReset();
        clearPlats();
        plat_x[0 +: 10] = 10'd320;
        plat_y[0 +: 10] = 10'd248;
        runFrame(8'd0, 1'b1, lat, sl);
        vectors++;
        if ({doodle_y, doodle_vy, sl} !== {10'd240, 10'd1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL vy0_no_land: got y=%0d vy=%0d landed=%b, required 240 1 0", doodle_y, doodle_vy, sl);
        end
        runFrame(8'd0, 1'b1, lat, sl);
        vectors++;
        if ({doodle_y, doodle_vy, landed_idx, sl} !== {10'd240, 10'h3F4, 6'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL edge_land: got y=%0d vy=%h idx=%0d landed=%b, required 240 3f4 0 1",
                     doodle_y, doodle_vy, landed_idx, sl);
        end
    endtask

    task automatic test_landing;
        int   lat;
        logic sl;
        doReset();
        clearPlats();
        plat_x[3*10 +: 10] = 10'd322;
        plat_y[3*10 +: 10] = 10'd260;
        plat_x[9*10 +: 10] = 10'd322;
        plat_y[9*10 +: 10] = 10'd260;
        for (int i = 1; i <= 5; i++) runFrame(8'd0, 1'b1, lat, sl);
        vectors++;
        if ({doodle_y, doodle_vy, sl} !== {10'd250, 10'd5, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL approach: got y=%0d vy=%0d landed=%b, required 250 5 0", doodle_y, doodle_vy, sl);
        end
        runFrame(8'd0, 1'b1, lat, sl);
        vectors++;
        if ({doodle_y, doodle_vy, landed_idx, sl} !== {10'd252, 10'h3F4, 6'd3, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL plat_land: got y=%0d vy=%h idx=%0d landed=%b, required 252 3f4 3 1",
                     doodle_y, doodle_vy, landed_idx, sl);
        end
        for (int i = 1; i <= 8; i++) runFrame(8'd0, 1'b1, lat, sl);
        vectors++;
        if ({doodle_y, doodle_vy} !== {10'd184, 10'h3FC}) begin
            miscompares++;
            $display("[TB] FAIL rise_vy_m4: got y=%0d vy=%h, required 184 3fc", doodle_y, doodle_vy);
        end
        runFrame(8'd0, 1'b1, lat, sl);
        vectors++;
        if ({doodle_y, doodle_vy, sl} !== {10'd180, 10'h3FD, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL rise_vy_m3: got y=%0d vy=%h landed=%b, required 180 3fd 0", doodle_y, doodle_vy, sl);
        end
    endtask

    task automatic test_horizontal;
        int   lat;
        logic sl;
        logic [7:0] keys [5]    = '{8'd4, 8'd80, 8'd79, 8'd7, 8'd5};
        logic [9:0] expectX [5] = '{10'd26, 10'd613, 10'd26, 10'd28, 10'd28};
        doReset();
        clearPlats();
        for (int i = 0; i < 146; i++) runFrame((i % 2 == 0) ? 8'd4 : 8'd80, 1'b1, lat, sl);
        vectors++;
        if (doodle_x !== 10'd28) begin
            miscompares++;
            $display("[TB] FAIL walk_left: got x=%0d, required 28", doodle_x);
        end
        for (int i = 0; i < 5; i++) begin
            runFrame(keys[i], 1'b1, lat, sl);
            vectors++;
            if (doodle_x !== expectX[i]) begin
                miscompares++;
                $display("[TB] FAIL wrap_step%0d: key=%0d got x=%0d, required %0d", i, keys[i], doodle_x, expectX[i]);
            end
        end
    endtask

    task automatic test_shots;
        int   lat;
        logic sl;
        doReset();
        clearPlats();
        runFrame(8'd30, 1'b1, lat, sl);
        vectors++;
        if ({shot_valid, shot_x[9:0], shot_y[9:0]} !== {4'b0001, 10'd320, 10'd240}) begin
            miscompares++;
            $display("[TB] FAIL spawn: got valid=%b x=%0d y=%0d, required 0001 320 240", shot_valid, shot_x[9:0], shot_y[9:0]);
        end
        for (int i = 2; i <= 20; i++) runFrame(8'd30, 1'b1, lat, sl);
        vectors++;
        if ({shot_valid, shot_y[9:0]} !== {4'b0001, 10'd107}) begin
            miscompares++;
            $display("[TB] FAIL held_fire: got valid=%b y0=%0d, required 0001 107", shot_valid, shot_y[9:0]);
        end
        runFrame(8'd0, 1'b1, lat, sl);
        runFrame(8'd30, 1'b1, lat, sl);
        vectors++;
        if ({shot_valid, shot_y[9:0], shot_x[19:10], shot_y[19:10]} !== {4'b0011, 10'd93, 10'd320, 10'd395}) begin
            miscompares++;
            $display("[TB] FAIL second_spawn: got valid=%b y0=%0d x1=%0d y1=%0d, required 0011 93 320 395",
                     shot_valid, shot_y[9:0], shot_x[19:10], shot_y[19:10]);
        end
        runFrame(8'd0, 1'b1, lat, sl);
        runFrame(8'd30, 1'b1, lat, sl);
        vectors++;
        if (shot_valid !== 4'b0011) begin
            miscompares++;
            $display("[TB] FAIL cooldown_block: got valid=%b, required 0011", shot_valid);
        end
        for (int i = 25; i <= 31; i++) runFrame(8'd0, 1'b1, lat, sl);
        vectors++;
        if ({shot_valid, shot_y[9:0]} !== {4'b0011, 10'd30}) begin
            miscompares++;
            $display("[TB] FAIL pre_retire: got valid=%b y0=%0d, required 0011 30", shot_valid, shot_y[9:0]);
        end
        runFrame(8'd0, 1'b1, lat, sl);
        vectors++;
        if ({shot_valid, shot_y[19:10]} !== {4'b0010, 10'd325}) begin
            miscompares++;
            $display("[TB] FAIL retire: got valid=%b y1=%0d, required 0010 325", shot_valid, shot_y[19:10]);
        end
    endtask

    // Runs straight after test_shots, so the Doodle sits at y=440, vy=-9 with slot 1 at y=325.
    task automatic test_freeze;
        int   lat;
        logic sl;
        runFrame(8'd4, 1'b0, lat, sl);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("[TB] FAIL latency_frozen: got %0d clocks, required 2", lat);
        end
        vectors++;
        if ({doodle_x, doodle_y, doodle_vy, shot_valid, shot_y[19:10]} !==
            {10'd320, 10'd440, 10'h3F7, 4'b0010, 10'd325}) begin
            miscompares++;
            $display("[TB] FAIL frozen_state: got x=%0d y=%0d vy=%h valid=%b y1=%0d, required 320 440 3f7 0010 325",
                     doodle_x, doodle_y, doodle_vy, shot_valid, shot_y[19:10]);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int extra;
        keycode = 8'd0;
        run     = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b1;
        @(posedge Clk);
        #1 frame_tick = 1'b0;
        lat = 0;
        repeat (4) begin
            @(posedge Clk);
            #1 lat++;
        end
        @(negedge Clk);
        frame_tick = 1'b1;
        @(posedge Clk);
        #1 frame_tick = 1'b0;
        lat++;
        while (!frame_done && lat < 100) begin
            @(posedge Clk);
            #1 lat++;
        end
        vectors++;
        if (lat !== 18) begin
            miscompares++;
            $display("[TB] FAIL b2b_latency: got %0d clocks, required 18", lat);
        end
        extra = 0;
        repeat (40) begin
            @(posedge Clk);
            #1 if (frame_done || busy) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_frame: got %0d busy/done clocks afterwards, required 0", extra);
        end
        vectors++;
        if ({doodle_y, doodle_vy, shot_y[19:10]} !== {10'd431, 10'h3F8, 10'd318}) begin
            miscompares++;
            $display("[TB] FAIL b2b_state: got y=%0d vy=%h y1=%0d, required 431 3f8 318", doodle_y, doodle_vy, shot_y[19:10]);
        end
`ifdef PHYS_OVERRUN_CNT_EN
        vectors++;
        if (overrun_cnt !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL overrun_cnt: got %0d, required 1", overrun_cnt);
        end
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_gravity_floor();
        test_rising_gate();
        test_landing();
        test_horizontal();
        test_shots();
        test_freeze();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
